// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mult_div_unit).
// Holds the op encodings, the FSM state encoding, the default datapath width
// and the iteration count.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_ITERS = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_ITERS);

    // op encodings: bit 1 selects divide, bit 0 selects unsigned
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    // FSM state encoding (IDLE/MUL/DIV/FIX)
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_FIX  = 2'b11;

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring unsigned divide core: one quotient bit per step_i, 32 steps.
// Only built when MDU_DIV_EN is defined; otherwise the file is empty.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          capture dividend/divisor and clear the partial remainder
//   step_i          perform one restoring iteration
//   dividend_i      unsigned dividend
//   divisor_i       unsigned divisor
//   quotient_o      quotient after 32 steps (all ones for divisor 0)
//   remainder_o     remainder after 32 steps (dividend for divisor 0)
`ifdef MDU_DIV_EN
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted_c;
    logic             fits_c;

    // One iteration: shift in the next dividend bit, subtract if it fits.
    // The quotient register doubles as the dividend shift register.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        shifted_c = {rem_q, quo_q[WIDTH-1]};
        fits_c    = (shifted_c >= {1'b0, dvs_q});
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = fits_c ? WIDTH'(shifted_c - {1'b0, dvs_q}) : shifted_c[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], fits_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU: shift-add, 32 cycles. DIV/DIVU: restoring divide, 32 cycles
// (only with MDU_DIV_EN defined; otherwise divide ops complete in one cycle
// and leave HI/LO untouched). A FIX cycle applies sign corrections.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   start, op               launch request (IDLE only) and operation
//   operand_a, operand_b    rs / rt values
//   hilo_we/sel/wdata       MTHI/MTLO write (IDLE only)
//   busy, done, div_zero    handshake status (registered)
//   hi, lo                  HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_res_q, neg_res_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 divz_q, divz_d;

    logic                 a_neg_c, b_neg_c;
    logic [WIDTH-1:0]     abs_a_c, abs_b_c;
    logic [WIDTH:0]       mul_sum_c;
    logic [2*WIDTH-1:0]   prod_fix_c;

    // Operand magnitudes; signed ops latch absolute values plus sign flags
    always_comb begin
        a_neg_c    = mdu_is_signed(op) & operand_a[WIDTH-1];
        b_neg_c    = mdu_is_signed(op) & operand_b[WIDTH-1];
        abs_a_c    = a_neg_c ? (~operand_a + WIDTH'(1)) : operand_a;
        abs_b_c    = b_neg_c ? (~operand_b + WIDTH'(1)) : operand_b;
        // acc = {partial product, remaining multiplier bits}; add on LSB, shift right
        mul_sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        prod_fix_c = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

`ifdef MDU_DIV_EN
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] quo_c, rem_c;
    logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk         (clock),
        .rst_n       (reset_n),
        .load_i      ((state_q == ST_IDLE) && start && mdu_is_div(op)),
        .step_i      (state_q == ST_DIV),
        .dividend_i  (abs_a_c),
        .divisor_i   (abs_b_c),
        .quotient_o  (quo_c),
        .remainder_o (rem_c)
    );

    // Quotient negative iff signs differ; remainder follows dividend sign
    always_comb begin
        quo_fix_c = neg_res_q ? (~quo_c + WIDTH'(1)) : quo_c;
        rem_fix_c = neg_rem_q ? (~rem_c + WIDTH'(1)) : rem_c;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divz_d    = 1'b0;
`ifdef MDU_DIV_EN
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hilo_we) begin
                    if (hilo_sel) hi_d = hilo_wdata;
                    else          lo_d = hilo_wdata;
                end
                if (start) begin
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = mdu_is_div(op);
                    neg_res_d = a_neg_c ^ b_neg_c;
                    mcand_d   = abs_a_c;
                    acc_d     = {{WIDTH{1'b0}}, abs_b_c};
`ifdef MDU_DIV_EN
                    neg_rem_d = a_neg_c;
                    b_zero_d  = (operand_b == '0);
                    state_d   = mdu_is_div(op) ? ST_DIV : ST_MUL;
`else
                    // No divider: divide ops go straight to FIX and write nothing
                    state_d   = mdu_is_div(op) ? ST_FIX : ST_MUL;
`endif
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) state_d = ST_FIX;
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                cnt_d = cnt_q + MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(MDU_ITERS - 1)) state_d = ST_FIX;
            end
`endif
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix_c;
                end
`ifdef MDU_DIV_EN
                else if (b_zero_q) begin
                    // Divide by zero: raw remainder equals |a|, so the dividend-sign
                    // fix restores operand_a exactly; quotient is forced to all ones
                    lo_d   = '1;
                    hi_d   = rem_fix_c;
                    divz_d = 1'b1;
                end else begin
                    lo_d = quo_fix_c;
                    hi_d = rem_fix_c;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divz_q    <= divz_d;
`ifdef MDU_DIV_EN
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random ops against an
// arithmetic reference model of HI/LO, latency and handshake behaviour.
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        hilo_we, hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int          n_checks;
    int          n_pass;
    logic [31:0] hi_m, lo_m;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hilo_we    (hilo_we),
        .hilo_sel   (hilo_sel),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: {div_zero, HI, LO} straight from integer arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi0, input logic [31:0] lo0);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (o == 2'b01) begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (!DIV_EN) return {1'b0, hi0, lo0};
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    // Assert start for one edge (optionally with an MTHI/MTLO), check busy rises
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit we, input bit sel, input logic [31:0] wd, input string tag);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        hilo_we = we; hilo_sel = sel; hilo_wdata = wd;
        @(posedge clock); #1;
        start = 1'b0; hilo_we = 1'b0;
        check_eq({tag, "_busy_rise"}, 64'(busy), 64'd1);
        if (we) begin
            if (sel) begin hi_m = wd; check_eq({tag, "_wr_hi"}, 64'(hi), 64'(wd)); end
            else     begin lo_m = wd; check_eq({tag, "_wr_lo"}, 64'(lo), 64'(wd)); end
        end
    endtask

    // Wait for done (bounded); optionally poke start/hilo_we/operands at cycle poke
    task automatic wait_done(input int exp_lat, input logic [64:0] exp_r, input int poke, input string tag);
        int cyc;
        bit seen, busy_ok;
        cyc = 0; seen = 0; busy_ok = 1;
        while (cyc < 40 && !seen) begin
            if (cyc == poke) begin
                start = 1'b1; op = 2'b01; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0000_0003;
                hilo_we = 1'b1; hilo_sel = cyc[0]; hilo_wdata = 32'hBAD0_BAD0;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        start = 1'b0; hilo_we = 1'b0;
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        check_eq({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check_eq({tag, "_hi"}, 64'(hi), 64'(exp_r[63:32]));
        check_eq({tag, "_lo"}, 64'(lo), 64'(exp_r[31:0]));
        check_eq({tag, "_div_zero"}, 64'(div_zero), 64'(exp_r[64]));
        hi_m = exp_r[63:32];
        lo_m = exp_r[31:0];
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit tail, input string tag);
        logic [64:0] r;
        int          lat;
        launch(o, a, b, 1'b0, 1'b0, 32'd0, tag);
        r   = ref_op(o, a, b, hi_m, lo_m);
        lat = (o[1] && !DIV_EN) ? 1 : 33;
        wait_done(lat, r, poke, tag);
        if (tail) begin
            @(posedge clock); #1;
            check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
            check_eq({tag, "_dz_pulse"}, 64'(div_zero), 64'd0);
            check_eq({tag, "_hi_hold"}, 64'(hi), 64'(hi_m));
            check_eq({tag, "_lo_hold"}, 64'(lo), 64'(lo_m));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          seen_done;
        logic [64:0] r;
        n_checks = 0; n_pass = 0;
        hi_m = '0; lo_m = '0;
        reset_n = 1'b0; start = 1'b0; op = 2'b00;
        operand_a = '0; operand_b = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dz", 64'(div_zero), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed multiplies
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, -1, 1, "mult_neg3x7");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1, "mult_minmin");

        // Directed divides (with no divider these complete in one cycle, HI/LO kept)
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1, "div_m7_2");
        run_op(2'b11, 32'd100, 32'd7, -1, 1, "divu_100_7");
        run_op(2'b11, 32'd5, 32'd0, -1, 1, "divu_5_0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1, 1, "div_m7_0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1, "div_min_m1");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, -1, 1, "div_7_m2");

        // MTHI / MTLO in IDLE
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h0000_1234;
        @(posedge clock); #1;
        hilo_we = 1'b0; hi_m = 32'h0000_1234;
        check_eq("mthi", 64'(hi), 64'h1234);
        check_eq("mthi_lo_kept", 64'(lo), 64'(lo_m));
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hCAFE_0001;
        @(posedge clock); #1;
        hilo_we = 1'b0; lo_m = 32'hCAFE_0001;
        check_eq("mtlo", 64'(lo), 64'hCAFE_0001);

        // MTHI together with an accepted divide start: write lands, result overwrites
        launch(2'b11, 32'd9, 32'd4, 1'b1, 1'b1, 32'h5555_AAAA, "we_start");
        r = ref_op(2'b11, 32'd9, 32'd4, hi_m, lo_m);
        wait_done(DIV_EN ? 33 : 1, r, -1, "we_start");

        // start / hilo_we / operand changes while busy are ignored
        run_op(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 5, 1, "poke_mid");
        run_op(2'b01, 32'h0BAD_F00D, 32'h0000_0101, 32, 1, "poke_fix");

        // Back-to-back: second start issued in the done cycle
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, -1, 0, "b2b_first");
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0005, -1, 1, "b2b_second");

        // Random mix
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), -1, (i % 3) != 0,
                   $sformatf("rand%0d", i));
        end

        // Reset 10 cycles into a MULT aborts without a done pulse
        launch(2'b00, 32'h0000_7777, 32'hFFFF_0003, 1'b0, 1'b0, 32'd0, "rst_mid");
        repeat (9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_hi", 64'(hi), 64'd0);
        check_eq("rst_mid_lo", 64'(lo), 64'd0);
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done || busy) seen_done++;
        end
        check_eq("rst_mid_no_done", 64'(seen_done), 64'd0);

        run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFE, -1, 1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
